// File: rtl/mod_data_mem_ctrl.sv
// mod_data_mem_ctrl: word-addressed data memory with fixed wait states and a processor hold
module mod_data_mem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_address,
    input  logic [31:0] write_data,
    output logic [31:0] data,
    output logic        hold,
    output logic        addr_error
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [ADDR_WIDTH-1:0] addr_q, acc_addr;
    logic [31:0] wdata_q, acc_wd;
    logic wr_q, both_q;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic request, invalid, go_now, finish, acc, acc_wr, acc_bad, acc_flag;

    assign request = mem_read | mem_write;
    assign invalid = (|data_address[1:0]) | (|data_address[31:ADDR_WIDTH+2]);
    // Zero-wait and rejected accesses resolve straight from IDLE using the live inputs
    assign go_now = state == IDLE && request && (WAIT_CYCLES == 0 || invalid);
    assign finish = state == WAIT && cnt == 0;
    assign acc = go_now | finish;
    assign acc_wr = go_now ? mem_write : wr_q;
    assign acc_addr = go_now ? data_address[ADDR_WIDTH+1:2] : addr_q;
    assign acc_wd = go_now ? write_data : wdata_q;
    assign acc_bad = go_now & invalid;
    assign acc_flag = go_now ? (invalid | (mem_read & mem_write)) : both_q;
    assign hold = !reset && ((state == IDLE && request) || state == WAIT);

    // Array commit; reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && acc && acc_wr && !acc_bad) mem[acc_addr] <= acc_wd;
    end

    // Access sequencing, request latching, read data and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            data <= '0;
            addr_error <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wr_q <= 1'b0;
            both_q <= 1'b0;
        end else begin
            addr_error <= acc & acc_flag;
            if (acc && !acc_wr) data <= acc_bad ? '0 : mem[acc_addr];
            case (state)
                IDLE: if (request) begin
                    addr_q <= data_address[ADDR_WIDTH+1:2];
                    wdata_q <= write_data;
                    wr_q <= mem_write;
                    both_q <= mem_read & mem_write;
                    cnt <= go_now ? '0 : 4'(WAIT_CYCLES - 1);
                    state <= go_now ? DONE : WAIT;
                end
                WAIT: if (cnt == 0) state <= DONE;
                      else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_data_mem_ctrl.sv
// tb_mod_data_mem_ctrl: transaction-level model check of two builds (2 and 0 wait states)
module tb_mod_data_mem_ctrl;
    logic clk = 0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wdv [2];
    logic [31:0] dq [2];
    logic        hq [2];
    logic        eq [2];

    mod_data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .data_address(ad[0]), .write_data(wdv[0]),
        .data(dq[0]), .hold(hq[0]), .addr_error(eq[0]));

    mod_data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .data_address(ad[1]), .write_data(wdv[1]),
        .data(dq[1]), .hold(hq[1]), .addr_error(eq[1]));

    int tests = 0;
    int fails = 0;
    int wc [2] = '{2, 0};
    logic [31:0] mm [2][256];
    logic [31:0] md [2];
    logic        exp_hold [2];
    logic        exp_err [2];
    logic [31:0] exp_data [2];
    logic [31:0] done_data [2];
    logic        done_err [2];
    bit          chk_en = 0;

    task automatic cmp(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the transaction model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                cmp("hold", d, 32'(hq[d]), 32'(exp_hold[d]));
                cmp("addr_error", d, 32'(eq[d]), 32'(exp_err[d]));
                cmp("data", d, dq[d], exp_data[d]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete access: hold phase, DONE cycle, then the dead cycle with strobes dropped
    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
        bit valid;
        int nh;
        valid = a[1:0] == 2'b00 && a[31:10] == 22'd0;
        nh = valid ? wc[d] + 1 : 1;
        rd[d] = r; wr[d] = w; ad[d] = a; wdv[d] = v;
        exp_hold[d] = 1; exp_err[d] = 0; exp_data[d] = md[d];
        repeat (nh) tick;
        if (w && valid) mm[d][a[9:2]] = v;
        if (r && !w) md[d] = valid ? mm[d][a[9:2]] : 32'd0;
        exp_hold[d] = 0; exp_err[d] = !valid || (r && w); exp_data[d] = md[d];
        done_data[d] = dq[d]; done_err[d] = eq[d];
        tick;
        rd[d] = 0; wr[d] = 0; exp_err[d] = 0;
        tick;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; rd[d] = 0; wr[d] = 0; ad[d] = 0; wdv[d] = 0;
            md[d] = 0; exp_hold[d] = 0; exp_err[d] = 0; exp_data[d] = 0;
        end
        tick;
        chk_en = 1;
        tick;
        cmp("reset_data", 0, dq[0], 32'd0);
        cmp("reset_hold", 0, 32'(hq[0]), 32'd0);
        rst[0] = 0; rst[1] = 0;
        tick;

        access(0, 0, 1, 32'h10, 32'hDEADBEEF);
        cmp("wr_err", 0, 32'(done_err[0]), 32'd0);
        access(0, 1, 0, 32'h10, 32'h0);
        cmp("rd_data", 0, done_data[0], 32'hDEADBEEF);
        cmp("rd_err", 0, 32'(done_err[0]), 32'd0);

        access(0, 1, 0, 32'h12, 32'h0);
        cmp("misalign_err", 0, 32'(done_err[0]), 32'd1);
        cmp("misalign_data", 0, done_data[0], 32'd0);
        access(0, 1, 0, 32'h10, 32'h0);
        cmp("reread_data", 0, done_data[0], 32'hDEADBEEF);

        access(0, 0, 1, 32'h0, 32'h1234);
        access(0, 0, 1, 32'h400, 32'h5);
        cmp("range_err", 0, 32'(done_err[0]), 32'd1);
        access(0, 1, 0, 32'h0, 32'h0);
        cmp("range_keep", 0, done_data[0], 32'h1234);

        access(0, 1, 1, 32'h20, 32'hA5A5A5A5);
        cmp("both_err", 0, 32'(done_err[0]), 32'd1);
        access(0, 1, 0, 32'h20, 32'h0);
        cmp("both_data", 0, done_data[0], 32'hA5A5A5A5);

        access(0, 0, 1, 32'h30, 32'h11);
        rd[0] = 0; wr[0] = 1; ad[0] = 32'h30; wdv[0] = 32'h77;
        exp_hold[0] = 1; exp_err[0] = 0; exp_data[0] = md[0];
        tick;
        rst[0] = 1; exp_hold[0] = 0;
        tick;
        rst[0] = 0; wr[0] = 0; md[0] = 0; exp_data[0] = 0;
        tick;
        cmp("abort_data", 0, dq[0], 32'd0);
        cmp("abort_hold", 0, 32'(hq[0]), 32'd0);
        tick;
        access(0, 1, 0, 32'h30, 32'h0);
        cmp("abort_keep", 0, done_data[0], 32'h11);

        access(1, 0, 1, 32'h0, 32'h1);
        access(1, 1, 0, 32'h0, 32'h0);
        cmp("w0_data", 1, done_data[1], 32'h1);
        access(1, 1, 0, 32'h12, 32'h0);
        cmp("w0_misalign_err", 1, 32'(done_err[1]), 32'd1);

        tick;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
